// File: rtl/rumo_pkg.sv
// Shared heading codes, controller state encoding and heading helpers
// for the robot heading command initiator.
package rumo_pkg;

  localparam logic [2:0] NORTE = 3'b001;
  localparam logic [2:0] OESTE = 3'b010;
  localparam logic [2:0] LESTE = 3'b011;
  localparam logic [2:0] SUL   = 3'b100;

  typedef enum logic [2:0] {
    OCIOSO,
    CHECA,
    GIRA,
    ESPERA,
    AVANCA,
    PAUSA,
    FIM,
    ERRO
  } estado_t;

  function automatic logic legal(input logic [2:0] code);
    return (code == NORTE) || (code == OESTE) || (code == LESTE) || (code == SUL);
  endfunction

  // Position in the rotation order N -> O -> S -> L -> N.
  function automatic logic [1:0] idx(input logic [2:0] code);
    logic [1:0] r;
    case (code)
      NORTE:   r = 2'd0;
      OESTE:   r = 2'd1;
      SUL:     r = 2'd2;
      LESTE:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] giros(input logic [2:0] alvo, input logic [2:0] atual);
    return idx(alvo) - idx(atual);
  endfunction

endpackage

// File: rtl/temporizador_espera.sv
// Loadable down-counter with a zero flag, shared by the rotation wait
// and the spacing between advance pulses.
module temporizador_espera #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         carga,
  input  logic [W-1:0] valor,
  input  logic         decr,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carga)
      cnt_d = valor;
    else if (decr && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/controle_rumo.sv
// Heading command initiator: rotates until the fed-back heading matches the
// target (with a timeout), then issues spaced advance pulses.
module controle_rumo
  import rumo_pkg::*;
#(
  parameter int PW      = 4,
  parameter int TIMEOUT = 8,
  parameter int GAP     = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_rumo,
  input  logic [PW-1:0] cmd_passos,
  input  logic [2:0]    orientacao,
  output logic          girar,
  output logic          avancar,
  output logic          ocupado,
  output logic          fim,
  output logic          erro
);

  localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  // The timeout is measured from the girar cycle, so ESPERA lasts TIMEOUT-1 cycles.
  localparam logic [TW-1:0] CARGA_ESPERA = TW'(TIMEOUT - 2);
  localparam logic [TW-1:0] CARGA_PAUSA  = TW'(GAP - 1);

  estado_t       estado_q, estado_d;
  logic [2:0]    alvo_q, alvo_d;
  logic [2:0]    prev_q, prev_d;
  logic [PW-1:0] passos_q, passos_d;
  logic          cmd_ready_q, ocupado_q, girar_q, avancar_q, fim_q, erro_q;

  logic          carga;
  logic [TW-1:0] valor;
  logic          decr;
  logic          zero;

  temporizador_espera #(.W(TW)) u_temporizador (
    .clock   (clock),
    .reset_n (reset_n),
    .carga   (carga),
    .valor   (valor),
    .decr    (decr),
    .zero    (zero)
  );

  always_comb begin
    estado_d = estado_q;
    alvo_d   = alvo_q;
    prev_d   = prev_q;
    passos_d = passos_q;
    carga    = 1'b0;
    valor    = '0;
    decr     = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (cmd_valid) begin
          alvo_d   = cmd_rumo;
          passos_d = cmd_passos;
          estado_d = legal(cmd_rumo) ? CHECA : ERRO;
        end
      end
      CHECA: begin
        if (!legal(orientacao))
          estado_d = ERRO;
        else if (orientacao == alvo_q)
          estado_d = (passos_q == '0) ? FIM : AVANCA;
        else
          estado_d = GIRA;
      end
      GIRA: begin
        prev_d   = orientacao;
        carga    = 1'b1;
        valor    = CARGA_ESPERA;
        estado_d = ESPERA;
      end
      ESPERA: begin
        // Any change of heading is progress; CHECA decides what comes next.
        if (orientacao != prev_q)
          estado_d = CHECA;
        else if (zero)
          estado_d = ERRO;
        else
          decr = 1'b1;
      end
      AVANCA: begin
        passos_d = passos_q - 1'b1;
        if (passos_q == PW'(1)) begin
          estado_d = FIM;
        end else begin
          carga    = 1'b1;
          valor    = CARGA_PAUSA;
          estado_d = PAUSA;
        end
      end
      PAUSA: begin
        if (zero)
          estado_d = AVANCA;
        else
          decr = 1'b1;
      end
      FIM:     estado_d = OCIOSO;
      ERRO:    estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      alvo_q      <= NORTE;
      prev_q      <= 3'b000;
      passos_q    <= '0;
      cmd_ready_q <= 1'b1;
      ocupado_q   <= 1'b0;
      girar_q     <= 1'b0;
      avancar_q   <= 1'b0;
      fim_q       <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      alvo_q      <= alvo_d;
      prev_q      <= prev_d;
      passos_q    <= passos_d;
      cmd_ready_q <= (estado_d == OCIOSO);
      ocupado_q   <= (estado_d != OCIOSO);
      girar_q     <= (estado_d == GIRA);
      avancar_q   <= (estado_d == AVANCA);
      fim_q       <= (estado_d == FIM);
      erro_q      <= (estado_d == ERRO);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign ocupado   = ocupado_q;
  assign girar     = girar_q;
  assign avancar   = avancar_q;
  assign fim       = fim_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_controle_rumo.sv
// Directed table-driven bench for controle_rumo with a one-cycle-delay
// orientation model and hand sequences for reset abort.
module tb_controle_rumo;

  localparam int PW      = 4;
  localparam int TIMEOUT = 8;
  localparam int GAP     = 4;
  localparam int LIMIT   = 200;

  localparam logic [2:0] N = 3'b001;
  localparam logic [2:0] O = 3'b010;
  localparam logic [2:0] L = 3'b011;
  localparam logic [2:0] S = 3'b100;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_rumo;
  logic [PW-1:0] cmd_passos;
  logic [2:0]    orientacao;
  logic          girar, avancar, ocupado, fim, erro;

  int n_vec = 0;
  int n_err = 0;

  controle_rumo #(.PW(PW), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rumo   (cmd_rumo),
    .cmd_passos (cmd_passos),
    .orientacao (orientacao),
    .girar      (girar),
    .avancar    (avancar),
    .ocupado    (ocupado),
    .fim        (fim),
    .erro       (erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]    ori;
    logic [2:0]    rumo;
    logic [PW-1:0] passos;
    bit            ignora;   // orientation model does not react to girar
    bit            poke;     // hold a bogus command on cmd_valid while busy
    int            exp_gir;
    int            exp_av;
    int            exp_fim;  // 1: ends with fim, 0: ends with erro
    int            exp_cyc;  // cycle (1 = first after accept) of the fim/erro pulse
  } vec_t;

  vec_t tab[11];

  function automatic logic [2:0] rot(input logic [2:0] h);
    case (h)
      N:       return O;
      O:       return S;
      S:       return L;
      L:       return N;
      default: return h;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int  k, done_k, first_gir, n_gir, n_av, last_av, bad_gap, viol, ended_fim;
    bit  pend, pg, pa;
    string tag;
    tag = $sformatf("v%0d", id);
    done_k = -1; first_gir = -1; n_gir = 0; n_av = 0; last_av = -1;
    bad_gap = 0; viol = 0; ended_fim = -1; pend = 0; pg = 0; pa = 0;
    orientacao = v.ori;
    cmd_valid  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cmd_rumo   = v.rumo;
    cmd_passos = v.passos;
    cmd_valid  = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    k = 1;
    while (done_k < 0 && k <= LIMIT) begin
      if (v.poke) begin
        cmd_valid = (k >= 2 && k <= 5);
        cmd_rumo  = 3'b000;
      end
      @(negedge clock);
      if (k == 1) check({tag, "_ready_low"}, cmd_ready, 0);
      if (v.poke && k >= 2 && k <= 5 && cmd_ready) viol++;
      if (girar && avancar) viol++;
      if ((girar && pg) || (avancar && pa)) viol++;
      pg = girar; pa = avancar;
      if (girar) begin
        n_gir++;
        if (first_gir < 0) first_gir = k;
        if (!v.ignora) pend = 1;
      end
      if (avancar) begin
        if (last_av >= 0 && (k - last_av) != GAP + 1) bad_gap++;
        last_av = k;
        n_av++;
      end
      if (fim || erro) begin
        done_k    = k;
        ended_fim = fim ? 1 : 0;
      end
      @(posedge clock);
      #1;
      if (pend) orientacao = rot(orientacao);
      pend = 0;
      k++;
    end
    @(negedge clock);
    check({tag, "_girar_count"}, n_gir, v.exp_gir);
    check({tag, "_avancar_count"}, n_av, v.exp_av);
    check({tag, "_end_kind"}, ended_fim, v.exp_fim);
    check({tag, "_end_cycle"}, done_k, v.exp_cyc);
    if (v.exp_gir > 0) check({tag, "_first_girar"}, first_gir, 2);
    if (v.exp_av > 1)  check({tag, "_avancar_gap"}, bad_gap, 0);
    check({tag, "_pulse_rules"}, viol, 0);
    check({tag, "_idle_after"}, int'({cmd_ready, ocupado, fim, erro}), 8);
  endtask

  initial begin
    int cnt;
    //        ori     rumo    passos ign poke gir av fim cyc
    tab[0]  = '{N,      S,      4'd0,  0, 0,  2,  0, 1,  8};
    tab[1]  = '{N,      L,      4'd2,  0, 0,  3,  2, 1,  17};
    tab[2]  = '{O,      O,      4'd0,  0, 0,  0,  0, 1,  2};
    tab[3]  = '{N,      3'b000, 4'd3,  0, 0,  0,  0, 0,  1};
    tab[4]  = '{N,      O,      4'd1,  1, 0,  1,  0, 0,  10};
    tab[5]  = '{S,      N,      4'd0,  0, 0,  2,  0, 1,  8};
    tab[6]  = '{L,      L,      4'd15, 0, 0,  0,  15, 1, 73};
    tab[7]  = '{3'b000, N,      4'd0,  0, 0,  0,  0, 0,  2};
    tab[8]  = '{N,      3'b111, 4'd0,  0, 0,  0,  0, 0,  1};
    tab[9]  = '{O,      N,      4'd1,  0, 0,  3,  1, 1,  12};
    tab[10] = '{N,      N,      4'd2,  0, 1,  0,  2, 1,  8};

    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_rumo   = 3'b000;
    cmd_passos = '0;
    orientacao = N;
    @(negedge clock);
    check("reset_outputs", int'({cmd_ready, ocupado, girar, avancar, fim, erro}), 32);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_after_reset", int'({cmd_ready, ocupado}), 2);

    for (int i = 0; i < 11; i++) run_vec(i, tab[i]);

    // Reset asserted while waiting between advance pulses.
    orientacao = N;
    @(posedge clock);
    #1;
    cmd_rumo = N; cmd_passos = 4'd3; cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cnt = 0;
    while (!avancar && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    check("abort_saw_avancar", int'(avancar), 1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_async_outputs", int'({cmd_ready, ocupado, girar, avancar, fim, erro}), 32);
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (fim || erro || avancar || girar) cnt++;
    end
    check("abort_no_activity", cnt, 0);
    check("abort_idle", int'({cmd_ready, ocupado}), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controle_rumo.md
Name: controle_rumo

Overview:
- Command-side initiator for the robot heading FSM.
- Accepts a target heading plus a step count over a valid/ready handshake.
- Issues single-cycle `girar` pulses until the fed-back `orientacao` code matches the target, then issues spaced `avancar` pulses, one per step.
- Sits between the navigation logic and the orientation/advance blocks. It closes the loop on `orientacao` with a timeout.

Parameters:
- PW, 4, width of step count.
- TIMEOUT, 8, max cycles to wait for an `orientacao` change after a `girar` pulse.
- GAP, 4, cycles between consecutive `avancar` pulses (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in OCIOSO).
- cmd_rumo  in  3  target heading: 001 Norte, 010 Oeste, 011 Leste, 100 Sul.
- cmd_passos  in  PW  number of advance steps (0 allowed).
- orientacao  in  3  current heading fed back from the orientation FSM.
- girar  out  1  one-cycle rotate request.
- avancar  out  1  one-cycle advance request.
- ocupado  out  1  high in any state except OCIOSO.
- fim  out  1  one-cycle pulse when a command completes successfully.
- erro  out  1  one-cycle pulse on an illegal command or a rotation timeout.

Behaviour:
- Reset (reset_n low, async):
  - State OCIOSO.
  - All outputs 0 except cmd_ready=1.
  - Counters 0, latched target 001.
  - Reset mid-operation aborts immediately. No `fim`/`erro` is emitted.
- Heading codes and rotation order:
  - Shared constants: Norte=001, Oeste=010, Leste=011, Sul=100.
  - Rotation order N→O→S→L→N, mapped to index 0,1,2,3.
  - Turns needed = (idx(target) − idx(current)) mod 4, giving 0..3, computed in 2-bit arithmetic.
- Accept:
  - A handshake occurs when cmd_valid && cmd_ready at a clock edge.
  - On handshake, latch cmd_rumo and cmd_passos; cmd_ready drops the next cycle.
- Illegal target code (000, 101, 110, 111):
  - erro=1 for one cycle, return to OCIOSO.
  - No girar or avancar issued.
- States:
  - OCIOSO: wait for handshake. Go to CHECA, or emit erro for an illegal code.
  - CHECA:
    - If orientacao == target, go to AVANCA (or FIM when passos=0).
    - If orientacao is an illegal code: erro, then OCIOSO.
    - Otherwise go to GIRA.
  - GIRA: girar=1 for exactly one cycle. Capture orientacao into prev. Go to ESPERA.
  - ESPERA:
    - Count cycles from 1.
    - When orientacao ≠ prev, go to CHECA and re-evaluate. Turns are therefore driven by feedback, not precomputed.
    - If the count reaches TIMEOUT with no change: erro pulse, then OCIOSO.
  - AVANCA:
    - avancar=1 for one cycle, decrement the remaining-step count.
    - If the count is now 0, go to FIM; else go to PAUSA.
  - PAUSA: wait GAP cycles, then AVANCA.
  - FIM: fim=1 for one cycle, then OCIOSO (cmd_ready=1 the following cycle).
- Output and timing rules:
  - girar and avancar are never high together.
  - Neither is ever high for two consecutive cycles.
  - Latency from accept to first girar is 2 cycles (OCIOSO→CHECA→GIRA).
- Command handling while busy:
  - cmd_valid while busy is ignored; no queuing.
- Boundary cases:
  - Target already equals orientacao and passos=0: fim 2 cycles after accept, no girar/avancar.
  - cmd_passos at its maximum (2^PW − 1) produces exactly that many avancar pulses. The counter must not wrap.
  - orientacao changing to a value that does not match the target still counts as progress: return to CHECA and continue.

Decomposition:
- Package rumo_pkg:
  - Heading code constants (Norte/Oeste/Leste/Sul).
  - State enum.
  - Function idx(code) → 2-bit, and the legality check.
- One sub-module, temporizador_espera: loadable down-counter shared by ESPERA (TIMEOUT) and PAUSA (GAP), with a zero flag.

Test Plan:
- Bench model: orientation model updates one cycle after each girar.
- orientacao=001, cmd_rumo=100, passos=0 → 2 girar pulses; orientacao 001→010→100; then fim; 0 avancar.
- orientacao=001, cmd_rumo=011, passos=2, GAP=4 → 3 girar; then 2 avancar pulses 5 cycles apart; then fim.
- orientacao=010, cmd_rumo=010, passos=0 → fim 2 cycles after accept; girar never asserted.
- cmd_rumo=000 → erro one cycle after accept; no girar; cmd_ready=1 again the next cycle.
- Model ignores girar, TIMEOUT=8 → one girar, then erro 8 cycles later, then OCIOSO.
- reset_n pulled low during PAUSA → all outputs 0 and cmd_ready=1 immediately (async); no fim afterwards.
